// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the conversion sequencer
package seq_pkg;

  // Default field widths for the sample-length and conversion-length inputs
  localparam int SAMP_W_DEF = 8;
  localparam int BIT_W_DEF  = 5;

  // Smallest phase length; a programmed length of zero is treated as this
  localparam int MIN_LEN = 1;

  // Sequencer phases, in frame order
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_SAMP = 3'd2,
    ST_COMP = 3'd3,
    ST_UPD  = 3'd4,
    ST_DONE = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_cnt.sv
// rtl/seq_cnt.sv - loadable down-counter with zero flag
module seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load wins over decrement; decrement saturates at zero so it can never wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - SAR conversion frame sequencer with registered phase outputs
module seq_gen
  import seq_pkg::*;
#(
  parameter int SAMP_W = SAMP_W_DEF,
  parameter int BIT_W  = BIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic [SAMP_W-1:0] samp_len,
  input  logic [BIT_W-1:0]  conv_len,
  output logic              seq_init,
  output logic              seq_samp,
  output logic              seq_comp,
  output logic              seq_update,
  output logic [BIT_W-1:0]  bit_idx,
  output logic              busy,
  output logic              done
);

  seq_state_t        state;
  seq_state_t        nxt;

  logic              load;
  logic              samp_dec;
  logic              bit_dec;
  logic [SAMP_W-1:0] samp_load;
  logic [BIT_W-1:0]  bit_load;
  logic [SAMP_W-1:0] samp_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              samp_zero;
  logic              bit_zero;

  logic              seq_init_d;
  logic              seq_samp_d;
  logic              seq_comp_d;
  logic              seq_update_d;
  logic              busy_d;
  logic              done_d;
  logic [BIT_W-1:0]  bit_idx_d;

  // Counters hold length-1 so the terminal cycle is the one where they read zero;
  // a zero length clamps to the minimum and therefore also loads zero
  always_comb begin
    samp_load = '0;
    bit_load  = '0;
    if (samp_len != '0) samp_load = samp_len - SAMP_W'(MIN_LEN);
    if (conv_len != '0) bit_load  = conv_len - BIT_W'(MIN_LEN);
  end

  // Sample-phase length counter: runs only while in SAMP
  seq_cnt #(.W(SAMP_W)) u_samp_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .dec      (samp_dec),
    .load_val (samp_load),
    .cnt      (samp_cnt),
    .zero     (samp_zero)
  );

  // Bit-decision counter: steps down once per UPD that loops back to COMP
  seq_cnt #(.W(BIT_W)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .dec      (bit_dec),
    .load_val (bit_load),
    .cnt      (bit_cnt),
    .zero     (bit_zero)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start) nxt = ST_INIT;
      ST_INIT: nxt = ST_SAMP;
      ST_SAMP: if (samp_zero) nxt = ST_COMP;
      ST_COMP: nxt = ST_UPD;
      ST_UPD:  nxt = bit_zero ? ST_DONE : ST_COMP;
      ST_DONE: nxt = cont ? ST_INIT : ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) nxt = ST_IDLE;
  end

  // Length capture happens only when a new frame begins, so mid-frame input
  // changes are invisible until the next frame
  always_comb begin
    load     = (state == ST_IDLE && nxt == ST_INIT) ||
               (state == ST_DONE && nxt == ST_INIT);
    samp_dec = (state == ST_SAMP) && (nxt == ST_SAMP);
    bit_dec  = (state == ST_UPD)  && (nxt == ST_COMP);
  end

  // Output decode from the next state so the flopped outputs line up with the state
  always_comb begin
    seq_init_d   = 1'b0;
    seq_samp_d   = 1'b0;
    seq_comp_d   = 1'b0;
    seq_update_d = 1'b0;
    done_d       = 1'b0;
    bit_idx_d    = '0;
    busy_d       = (nxt != ST_IDLE);
    case (nxt)
      ST_INIT: seq_init_d = 1'b1;
      ST_SAMP: seq_samp_d = 1'b1;
      ST_COMP: begin
        seq_comp_d = 1'b1;
        bit_idx_d  = (state == ST_UPD) ? bit_cnt - BIT_W'(1) : bit_cnt;
      end
      ST_UPD: begin
        seq_update_d = 1'b1;
        bit_idx_d    = bit_idx;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Output flops: every output is registered so the analog switch controls never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_init   <= 1'b0;
      seq_samp   <= 1'b0;
      seq_comp   <= 1'b0;
      seq_update <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_idx    <= '0;
    end else begin
      seq_init   <= seq_init_d;
      seq_samp   <= seq_samp_d;
      seq_comp   <= seq_comp_d;
      seq_update <= seq_update_d;
      busy       <= busy_d;
      done       <= done_d;
      bit_idx    <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - directed self-checking bench for seq_gen
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       cont;
  logic [7:0] samp_len;
  logic [4:0] conv_len;
  logic       seq_init;
  logic       seq_samp;
  logic       seq_comp;
  logic       seq_update;
  logic [4:0] bit_idx;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Phase vector: {init, samp, comp, update, busy, done}
  localparam logic [5:0] PH_IDLE = 6'b000000;
  localparam logic [5:0] PH_INIT = 6'b100010;
  localparam logic [5:0] PH_SAMP = 6'b010010;
  localparam logic [5:0] PH_COMP = 6'b001010;
  localparam logic [5:0] PH_UPD  = 6'b000110;
  localparam logic [5:0] PH_DONE = 6'b000011;

  logic [5:0] ph;
  assign ph = {seq_init, seq_samp, seq_comp, seq_update, busy, done};

  always #5 clk = ~clk;

  seq_gen #(.SAMP_W(8), .BIT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cont       (cont),
    .samp_len   (samp_len),
    .conv_len   (conv_len),
    .seq_init   (seq_init),
    .seq_samp   (seq_samp),
    .seq_comp   (seq_comp),
    .seq_update (seq_update),
    .bit_idx    (bit_idx),
    .busy       (busy),
    .done       (done)
  );

  // Phase outputs must be one-hot or all zero on every cycle
  always @(negedge clk) begin
    checks++;
    assert ($onehot0({seq_init, seq_samp, seq_comp, seq_update})) else begin
      errors++;
      $error("FAIL onehot observed=%b expected=onehot0", {seq_init, seq_samp, seq_comp, seq_update});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ph(input string tag, input logic [5:0] exp_ph, input int exp_idx);
    chk({tag, "_ph"}, 32'(ph), 32'(exp_ph));
    chk({tag, "_idx"}, 32'(bit_idx), 32'(exp_idx));
  endtask

  // Expected frame from the INIT cycle through DONE for clamped lengths s and c
  task automatic expect_frame(input string tag, input int s, input int c);
    chk_ph({tag, "_init"}, PH_INIT, 0);
    for (int i = 0; i < s; i++) begin
      step();
      chk_ph({tag, "_samp"}, PH_SAMP, 0);
    end
    for (int b = c - 1; b >= 0; b--) begin
      step();
      chk_ph({tag, "_comp"}, PH_COMP, b);
      step();
      chk_ph({tag, "_upd"}, PH_UPD, b);
    end
    step();
    chk_ph({tag, "_done"}, PH_DONE, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    cont     = 1'b0;
    samp_len = 8'd0;
    conv_len = 5'd0;
    step();
    step();
    chk_ph("reset", PH_IDLE, 0);
    rst = 1'b0;
    step();
    chk_ph("idle", PH_IDLE, 0);

    // V1: S=4, C=3; lengths changed mid-frame must not matter
    samp_len = 8'd4;
    conv_len = 5'd3;
    pulse_start();
    samp_len = 8'd9;
    conv_len = 5'd7;
    expect_frame("v1", 4, 3);
    start = 1'b1;
    step();
    chk_ph("v1_done_start_ignored", PH_IDLE, 0);
    start = 1'b0;
    step();
    chk_ph("v1_idle", PH_IDLE, 0);

    // V2: zero lengths clamp to one
    samp_len = 8'd0;
    conv_len = 5'd0;
    pulse_start();
    expect_frame("v2", 1, 1);
    step();
    chk_ph("v2_idle", PH_IDLE, 0);

    // V3: continuous mode, three back-to-back frames
    samp_len = 8'd2;
    conv_len = 5'd2;
    cont     = 1'b1;
    pulse_start();
    expect_frame("v3a", 2, 2);
    step();
    expect_frame("v3b", 2, 2);
    step();
    cont = 1'b0;
    expect_frame("v3c", 2, 2);
    step();
    chk_ph("v3_idle", PH_IDLE, 0);

    // V4: start while busy ignored, abort in the second COMP
    samp_len = 8'd1;
    conv_len = 5'd3;
    pulse_start();
    chk_ph("v4_init", PH_INIT, 0);
    step();
    chk_ph("v4_samp", PH_SAMP, 0);
    step();
    chk_ph("v4_comp1", PH_COMP, 2);
    start = 1'b1;
    step();
    chk_ph("v4_upd1", PH_UPD, 2);
    step();
    chk_ph("v4_comp2", PH_COMP, 1);
    abort = 1'b1;
    start = 1'b0;
    step();
    chk_ph("v4_abort", PH_IDLE, 0);
    abort = 1'b0;
    step();
    chk_ph("v4_idle", PH_IDLE, 0);

    // V5: asynchronous reset in SAMP, then a full frame
    samp_len = 8'd6;
    conv_len = 5'd2;
    pulse_start();
    chk_ph("v5_init", PH_INIT, 0);
    step();
    chk_ph("v5_samp", PH_SAMP, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_ph("v5_async_rst", PH_IDLE, 0);
    step();
    rst = 1'b0;
    step();
    chk_ph("v5_after_rst", PH_IDLE, 0);
    samp_len = 8'd3;
    pulse_start();
    expect_frame("v5", 3, 2);
    step();
    chk_ph("v5_idle", PH_IDLE, 0);

    // V6: all-ones lengths must not wrap
    samp_len = 8'd255;
    conv_len = 5'd31;
    pulse_start();
    expect_frame("v6", 255, 31);
    step();
    chk_ph("v6_idle", PH_IDLE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
